// File: rtl/mips_instr_encoder.sv
// Buffered MIPS instruction encoder: packs op requests into 32-bit words and queues them in a FIFO.
// Optional enqueue counter built only when MIPS_ENC_COUNT_EN is defined; otherwise enc_count reads 0.
module mips_instr_encoder #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [4:0]  req_rs,
  input  logic [4:0]  req_rt,
  input  logic [4:0]  req_rd,
  input  logic [5:0]  req_funct,
  input  logic [15:0] req_imm,
  input  logic [25:0] req_target,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic        err,
  input  logic        err_clr,
  output logic [15:0] enc_count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [31:0]   r_mem [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic [31:0]   r_instr;
  logic          r_err;

  logic          w_full;
  logic          w_empty;
  logic          w_accept;
  logic          w_legal;
  logic          w_push;
  logic          w_pop;
  logic [31:0]   w_word;
  logic [PW-1:0] w_rptr_nxt;
  logic [CW-1:0] w_count_nxt;
  logic [31:0]   w_head_nxt;

  assign w_full   = (r_count == CW'(DEPTH));
  assign w_empty  = (r_count == '0);
  assign w_accept = req_valid && !w_full;
  assign w_legal  = (req_op <= 3'd5);
  assign w_push   = w_accept && w_legal;
  assign w_pop    = !w_empty && instr_ready;

  always_comb begin
    w_word = 32'h0;
    case (req_op)
      3'd0:    w_word = {6'b000000, req_rs, req_rt, req_rd, 5'b00000, req_funct};
      3'd1:    w_word = {6'b100011, req_rs, req_rt, req_imm};
      3'd2:    w_word = {6'b101011, req_rs, req_rt, req_imm};
      3'd3:    w_word = {6'b000101, req_rs, req_rt, req_imm};
      3'd4:    w_word = {6'b001110, req_rs, req_rt, req_imm};
      3'd5:    w_word = {6'b000010, req_target};
      default: w_word = 32'h0;
    endcase
  end

  // The output word is a register tracking the next head; a push into an
  // otherwise empty slot becomes the head directly, and an empty FIFO holds.
  always_comb begin
    w_rptr_nxt  = w_pop ? (r_rptr + PW'(1)) : r_rptr;
    w_count_nxt = r_count;
    if (w_push && !w_pop)      w_count_nxt = r_count + CW'(1);
    else if (!w_push && w_pop) w_count_nxt = r_count - CW'(1);
    w_head_nxt = r_instr;
    if (w_count_nxt != '0) begin
      if (w_push && (r_wptr == w_rptr_nxt)) w_head_nxt = w_word;
      else                                  w_head_nxt = r_mem[w_rptr_nxt];
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n && w_push) r_mem[r_wptr] <= w_word;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_instr <= 32'h0;
      r_err   <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      r_rptr  <= w_rptr_nxt;
      r_count <= w_count_nxt;
      r_instr <= w_head_nxt;
      if (w_accept && !w_legal) r_err <= 1'b1;
      else if (err_clr)         r_err <= 1'b0;
    end
  end

`ifdef MIPS_ENC_COUNT_EN
  logic [15:0] r_enc_count;

  always_ff @(posedge clk) begin
    if (!reset_n)    r_enc_count <= 16'h0;
    else if (w_push) r_enc_count <= r_enc_count + 16'h1;
  end

  assign enc_count = r_enc_count;
`else
  assign enc_count = 16'h0;
`endif

  assign req_ready   = !w_full;
  assign instr_valid = !w_empty;
  assign instr       = r_instr;
  assign err         = r_err;

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Self-checking bench for mips_instr_encoder: directed scenarios plus randomized traffic
// against a queue-based reference model. enc_count expectation follows MIPS_ENC_COUNT_EN.
module tb_mips_instr_encoder;
  localparam int DEPTH = 4;

  logic        clk;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [4:0]  req_rs, req_rt, req_rd;
  logic [5:0]  req_funct;
  logic [15:0] req_imm;
  logic [25:0] req_target;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        err;
  logic        err_clr;
  logic [15:0] enc_count;

  mips_instr_encoder #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd), .req_funct(req_funct),
    .req_imm(req_imm), .req_target(req_target),
    .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .err(err), .err_clr(err_clr), .enc_count(enc_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] q[$];
  logic        m_err  = 1'b0;
  logic [15:0] m_cnt  = 16'h0;
  logic [31:0] m_last = 32'h0;
  logic        m_acc  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_enc(input int op, input int rs, input int rt, input int rd,
                                          input int funct, input int imm, input int target);
    logic [31:0] regs;
    regs = (32'(rs & 31) << 21) + (32'(rt & 31) << 16);
    case (op)
      0: return regs + (32'(rd & 31) << 11) + 32'(funct & 63);
      1: return (32'd35 << 26) + regs + 32'(imm & 16'hFFFF);
      2: return (32'd43 << 26) + regs + 32'(imm & 16'hFFFF);
      3: return (32'd5  << 26) + regs + 32'(imm & 16'hFFFF);
      4: return (32'd14 << 26) + regs + 32'(imm & 16'hFFFF);
      5: return (32'd2  << 26) + 32'(target & 26'h3FFFFFF);
      default: return 32'h0;
    endcase
  endfunction

  task automatic set_req(input int op, input int rs, input int rt, input int rd,
                         input int funct, input int imm, input int target);
    req_valid  = 1'b1;
    req_op     = 3'(op);
    req_rs     = 5'(rs);
    req_rt     = 5'(rt);
    req_rd     = 5'(rd);
    req_funct  = 6'(funct);
    req_imm    = 16'(imm);
    req_target = 26'(target);
  endtask

  // Advance one clock: update the model from the inputs seen at the edge, then check outputs.
  task automatic tick();
    logic acc, pop;
    @(posedge clk);
    acc   = req_valid && (q.size() < DEPTH);
    pop   = instr_ready && (q.size() > 0);
    m_acc = 1'b0;
    if (!reset_n) begin
      q.delete();
      m_err  = 1'b0;
      m_cnt  = 16'h0;
      m_last = 32'h0;
    end else begin
      m_acc = acc;
      if (pop) void'(q.pop_front());
      if (acc && req_op < 3'd6) begin
        q.push_back(ref_enc(req_op, req_rs, req_rt, req_rd, req_funct, req_imm, req_target));
        m_cnt = m_cnt + 16'h1;
      end
      if (acc && req_op >= 3'd6) m_err = 1'b1;
      else if (err_clr)          m_err = 1'b0;
      if (q.size() > 0) m_last = q[0];
    end
    @(negedge clk);
    chk("instr_valid", instr_valid, q.size() != 0);
    chk("instr", instr, m_last);
    chk("req_ready", req_ready, q.size() < DEPTH);
    chk("err", err, m_err);
`ifdef MIPS_ENC_COUNT_EN
    chk("enc_count", enc_count, m_cnt);
`else
    chk("enc_count", enc_count, 16'h0);
`endif
  endtask

  task automatic drain();
    req_valid   = 1'b0;
    instr_ready = 1'b1;
    for (int i = 0; i < DEPTH + 2; i++) tick();
    instr_ready = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; req_valid = 1'b0; instr_ready = 1'b0; err_clr = 1'b0;
    set_req(0, 0, 0, 0, 0, 0, 0);
    req_valid = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;

    // Single R-type
    set_req(0, 1, 2, 3, 6'h20, 16'hABCD, 26'h3FFFFFF);
    tick();
    req_valid = 1'b0;
    chk("rtype_word", instr, 32'h00221820);
    chk("rtype_valid", instr_valid, 1'b1);

    // All ops back-to-back, consumer always ready
    instr_ready = 1'b1;
    set_req(1, 4, 5, 31, 63, 16'h0010, 26'h1234567); tick(); chk("lw_word", instr, 32'h8C850010);
    set_req(2, 4, 5, 9, 1, 16'hFFFC, 26'h2AAAAAA);  tick(); chk("sw_word", instr, 32'hAC85FFFC);
    set_req(3, 1, 2, 7, 5, 16'hFFFE, 26'h0);        tick(); chk("bne_word", instr, 32'h1422FFFE);
    set_req(4, 0, 7, 3, 9, 16'h00FF, 26'h1);        tick(); chk("xori_word", instr, 32'h380700FF);
    set_req(5, 31, 31, 31, 63, 16'hFFFF, 26'h40);   tick(); chk("j_word", instr, 32'h08000040);
    drain();

    // Backpressure: five requests into a four-deep FIFO
    instr_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      set_req(1, k, k + 1, 0, 0, 16'h100 + k, 0);
      for (int t = 0; t < 8; t++) begin
        if (k == 4 && t == 2) instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        if (m_acc) break;
      end
    end
    req_valid = 1'b0;
    chk("bp_full_ready", req_ready, 1'b0);
    drain();

    // Illegal op between two legal ones
    set_req(4, 3, 4, 0, 0, 16'h5555, 0); tick();
    set_req(6, 1, 1, 1, 1, 1, 1);         tick();
    set_req(4, 5, 6, 0, 0, 16'hAAAA, 0); tick();
    req_valid = 1'b0;
    tick();
    chk("ill_err_set", err, 1'b1);
    drain();
    chk("ill_err_sticky", err, 1'b1);
    set_req(7, 0, 0, 0, 0, 0, 0); err_clr = 1'b1; tick();
    chk("ill_err_setwins", err, 1'b1);
    req_valid = 1'b0; tick();
    chk("ill_err_cleared", err, 1'b0);
    err_clr = 1'b0;

    // Hold occupancy at two while pushing and popping every cycle
    instr_ready = 1'b0;
    set_req(0, 9, 10, 11, 6'h22, 0, 0); tick();
    set_req(0, 12, 13, 14, 6'h24, 0, 0); tick();
    instr_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      set_req(k % 6, k, 31 - k, k + 3, k * 5, 16'h1111 * k, 26'h10000 + k);
      tick();
    end
    drain();

    // Reset mid-stream with a concurrent handshake
    set_req(1, 1, 2, 0, 0, 16'h1, 0); tick();
    set_req(2, 3, 4, 0, 0, 16'h2, 0); tick();
    set_req(6, 0, 0, 0, 0, 0, 0);     tick();
    set_req(3, 5, 6, 0, 0, 16'h3, 0); tick();
    set_req(5, 0, 0, 0, 0, 0, 26'h77); reset_n = 1'b0; tick();
    reset_n = 1'b1; req_valid = 1'b0;
    chk("rst_valid", instr_valid, 1'b0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_ready", req_ready, 1'b1);
    chk("rst_err", err, 1'b0);
    chk("rst_count", enc_count, 16'h0);
    tick();
    chk("rst_dropped", instr_valid, 1'b0);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      reset_n     = ($urandom_range(0, 299) != 0);
      err_clr     = ($urandom_range(0, 15) == 0);
      instr_ready = ($urandom_range(0, 3) != 0);
      set_req($urandom_range(0, 7), $urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
      req_valid   = ($urandom_range(0, 2) != 0);
      tick();
    end
    reset_n = 1'b1; err_clr = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/mips_instr_encoder.md
# mips_instr_encoder

- Buffered instruction encoder for the single-cycle MIPS datapath; it is the inverse of the control-unit opcode decoder.
- Accepts operation requests over a valid/ready handshake and packs the fields into 32-bit MIPS instruction words.
- Holds the words in a small FIFO and presents them on a valid/ready output port to the instruction memory loader or the testbench instruction stream.
- Supports exactly the decoded instruction set: R-type, lw, sw, bne, xori, j.

## Interface
- `DEPTH`, default 4: FIFO entries; power of two, at least 2.
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: reset, synchronous, active-low.
- `req_valid` in 1: request present.
- `req_ready` out 1: encoder can accept a request.
- `req_op` in 3: operation code. 0 = R-type, 1 = lw, 2 = sw, 3 = bne, 4 = xori, 5 = j, 6 and 7 are illegal.
- `req_rs`, `req_rt`, `req_rd` in 5 each: register fields.
- `req_funct` in 6: R-type funct.
- `req_imm` in 16: immediate or branch offset.
- `req_target` in 26: jump target.
- `instr` out 32: encoded word at the FIFO head.
- `instr_valid` out 1: `instr` is valid.
- `instr_ready` in 1: consumer takes `instr`.
- `err` out 1: sticky illegal-op flag.
- `err_clr` in 1: clears `err`.
- `enc_count` out 16: number of words enqueued; see Configuration.

## Operation
- **Accept:** a request is accepted on a rising edge with `req_valid && req_ready`.
- **`req_ready`:** equals `!full`. It does not look ahead at a same-cycle pop.
- **Encoding** (shamt is always 5'b0):
  - R-type: {000000, rs, rt, rd, 00000, funct}
  - lw: {100011, rs, rt, imm}
  - sw: {101011, rs, rt, imm}
  - bne: {000101, rs, rt, imm}
  - xori: {001110, rs, rt, imm}
  - j: {000010, target}
- **Unused fields:** fields not used by an op are ignored. They never leak into the word.
- **Illegal op (6 or 7):**
  - The handshake still completes.
  - Nothing is enqueued.
  - `err` is set on that edge.
  - `enc_count` does not change.
- **`err`:** stays set until an edge with `err_clr` = 1. If an illegal accept and `err_clr` occur on the same edge, the set wins and `err` = 1.
- **FIFO:** write pointer, read pointer, occupancy count `DEPTH`+1 values wide. Both pointers wrap modulo `DEPTH`.
- **Dequeue:** a word is removed on a rising edge with `instr_valid && instr_ready`.
- **Outputs from the head:** `instr_valid` = `!empty`. `instr` = the head entry, driven from registered storage (no combinational path from `req_*`).
- **Push and pop on the same edge:** occupancy is unchanged and both pointers advance. This is legal at any occupancy where both are individually permitted. A full FIFO cannot push (`req_ready` = 0), so a full FIFO with a pop only decrements.
- **Empty FIFO:** `instr` holds the last value read. The consumer must ignore it while `instr_valid` = 0.
- **Reset:** synchronous, active-low. On an edge with `reset_n` = 0:
  - Pointers and occupancy go to 0 and the contents are discarded.
  - `instr_valid` = 0, `instr` = 32'h0, `req_ready` = 1 (on the next cycle), `err` = 0, `enc_count` = 0.
  - A handshake on a reset edge is dropped. This holds mid-stream as well.

## Timing
- **Latency:** a legal request accepted at edge N appears at the head with `instr_valid` = 1 in the cycle after N, if the FIFO was empty.
- **Throughput:** 1 word/cycle sustained with `instr_ready` held at 1.
- **`req_ready`:** drops in the cycle after the edge that fills the FIFO. It rises in the cycle after the first pop from a full FIFO.
- **Order:** words are strictly in acceptance order, with illegal requests skipped.
- **Combinational paths:** none from `instr_ready` to `req_ready` and none from `req_*` to `instr*`.

## Configuration
- **Macro:** `MIPS_ENC_COUNT_EN`.
- **Defined:**
  - `enc_count` increments by 1 on each edge that enqueues a legal word.
  - It wraps from 16'hFFFF to 16'h0000.
  - It resets to 0.
  - It is unaffected by illegal ops and by pops.
- **Undefined:** the counter register is not built and `enc_count` is tied to 16'h0000. All other behaviour is identical.

## Test plan
- **Reset and single R-type:**
  - Stimulus: release `reset_n` after 2 cycles, then accept op=0, rs=1, rt=2, rd=3, funct=6'h20.
  - Response: `instr` = 32'h00221820 with `instr_valid` = 1 one cycle later, and `enc_count` = 1 when the macro is defined.
- **All ops, back-to-back, `instr_ready` = 1:**
  - Stimulus and expected words:
    - lw rs=4, rt=5, imm=16'h0010 -> 32'h8C850010
    - sw rs=4, rt=5, imm=16'hFFFC -> 32'hAC85FFFC
    - bne rs=1, rt=2, imm=16'hFFFE -> 32'h1422FFFE
    - xori rs=0, rt=7, imm=16'h00FF -> 32'h380700FF
    - j target=26'h0000040 -> 32'h08000040
  - Response: one word per cycle, in the order above.
- **Full/backpressure:**
  - Stimulus: `DEPTH` = 4, `instr_ready` = 0, 5 requests offered.
  - Response: 4 accepted, and `req_ready` = 0 from the cycle after the 4th accept.
  - Then raise `instr_ready` for 1 cycle: `req_ready` = 1 next cycle and the 5th request is accepted. The order is preserved.
- **Illegal op:**
  - Stimulus: op=6 between two legal requests.
  - Response: the handshake completes, only 2 words are output, `err` = 1 sticky, and `enc_count` = 2.
  - `err_clr` on the same edge as a second illegal accept leaves `err` = 1. `err_clr` alone clears it to 0.
- **Simultaneous push/pop and wrap:**
  - Stimulus: hold occupancy at 2 while pushing and popping every cycle for 10 cycles.
  - Response: occupancy stays 2, the pointers wrap, and the output sequence equals the input sequence.
- **Reset mid-operation:**
  - Stimulus: FIFO holding 3 words, `reset_n` = 0 for 1 edge with a concurrent handshake.
  - Response: next cycle `instr_valid` = 0, `instr` = 0, `req_ready` = 1, `err` = 0, `enc_count` = 0, and the concurrent request is not enqueued.
